// File: rtl/sdram_arb2.sv
// Two-port round-robin arbiter in front of a single SDRAM controller command port.
// Grants one transaction at a time, then forwards the ack and any read data to the winner.
module sdram_arb2 #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rh_wl,
    input  logic [DATA_W-1:0] m0_data_w,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_data_r,
    output logic              m0_data_r_en,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rh_wl,
    input  logic [DATA_W-1:0] m1_data_w,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_data_r,
    output logic              m1_data_r_en,
    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rh_wl,
    output logic [DATA_W-1:0] sdram_data_w,
    input  logic              sdram_ack,
    input  logic [DATA_W-1:0] sdram_data_r,
    input  logic              sdram_data_r_en,
    output logic              rd_timeout
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sdram_req_q, sdram_req_d;
    logic [ADDR_W-1:0]      sdram_addr_q, sdram_addr_d;
    logic                   sdram_rh_wl_q, sdram_rh_wl_d;
    logic [DATA_W-1:0]      sdram_data_w_q, sdram_data_w_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             data_r_en_q, data_r_en_d;
    logic [1:0][DATA_W-1:0] data_r_q, data_r_d;
    logic                   rd_timeout_q, rd_timeout_d;
    logic [1:0]             eligible;
    logic                   gsel;

    // A port whose ack is still pulsing has just been served; masking it stops a re-grant.
    assign eligible = {m1_req & ~ack_q[1], m0_req & ~ack_q[0]};

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        cnt_d          = cnt_q;
        sdram_req_d    = sdram_req_q;
        sdram_addr_d   = sdram_addr_q;
        sdram_rh_wl_d  = sdram_rh_wl_q;
        sdram_data_w_d = sdram_data_w_q;
        ack_d          = '0;
        data_r_en_d    = '0;
        data_r_d       = data_r_q;
        rd_timeout_d   = 1'b0;
        gsel           = (eligible == 2'b11) ? ~last_grant_q : eligible[1];

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_d        = gsel;
                    last_grant_d   = gsel;
                    sdram_req_d    = 1'b1;
                    sdram_addr_d   = gsel ? m1_addr   : m0_addr;
                    sdram_rh_wl_d  = gsel ? m1_rh_wl  : m0_rh_wl;
                    sdram_data_w_d = gsel ? m1_data_w : m0_data_w;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (sdram_ack) begin
                    sdram_req_d     = 1'b0;
                    ack_d[grant_q]  = 1'b1;
                    if (sdram_rh_wl_q) begin
                        cnt_d   = CNT_W'(RD_TIMEOUT);
                        state_d = WAIT_RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RD: begin
                // Data arriving in the last allowed cycle still beats the timeout.
                if (sdram_data_r_en) begin
                    data_r_d[grant_q]    = sdram_data_r;
                    data_r_en_d[grant_q] = 1'b1;
                    cnt_d                = '0;
                    state_d              = IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    rd_timeout_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            grant_q        <= 1'b0;
            cnt_q          <= '0;
            sdram_req_q    <= 1'b0;
            sdram_addr_q   <= '0;
            sdram_rh_wl_q  <= 1'b1;
            sdram_data_w_q <= '0;
            ack_q          <= '0;
            data_r_en_q    <= '0;
            data_r_q       <= '0;
            rd_timeout_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            cnt_q          <= cnt_d;
            sdram_req_q    <= sdram_req_d;
            sdram_addr_q   <= sdram_addr_d;
            sdram_rh_wl_q  <= sdram_rh_wl_d;
            sdram_data_w_q <= sdram_data_w_d;
            ack_q          <= ack_d;
            data_r_en_q    <= data_r_en_d;
            data_r_q       <= data_r_d;
            rd_timeout_q   <= rd_timeout_d;
        end
    end

    assign sdram_req    = sdram_req_q;
    assign sdram_addr   = sdram_addr_q;
    assign sdram_rh_wl  = sdram_rh_wl_q;
    assign sdram_data_w = sdram_data_w_q;
    assign m0_ack       = ack_q[0];
    assign m1_ack       = ack_q[1];
    assign m0_data_r_en = data_r_en_q[0];
    assign m1_data_r_en = data_r_en_q[1];
    assign m0_data_r    = data_r_q[0];
    assign m1_data_r    = data_r_q[1];
    assign rd_timeout   = rd_timeout_q;

endmodule

// File: tb/tb_sdram_arb2.sv
// Bench for sdram_arb2: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_sdram_arb2;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic          m0_req = 0, m1_req = 0;
    logic [AW-1:0] m0_addr = 0, m1_addr = 0;
    logic          m0_rh_wl = 0, m1_rh_wl = 0;
    logic [DW-1:0] m0_data_w = 0, m1_data_w = 0;
    logic          m0_ack, m1_ack, m0_data_r_en, m1_data_r_en;
    logic [DW-1:0] m0_data_r, m1_data_r;
    logic          sdram_req, sdram_rh_wl, rd_timeout;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_data_w;
    logic          sdram_ack = 0, sdram_data_r_en = 0;
    logic [DW-1:0] sdram_data_r = 0;

    always #5 clk = ~clk;

    sdram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset_l(reset_l),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rh_wl(m0_rh_wl), .m0_data_w(m0_data_w),
        .m0_ack(m0_ack), .m0_data_r(m0_data_r), .m0_data_r_en(m0_data_r_en),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_rh_wl(m1_rh_wl), .m1_data_w(m1_data_w),
        .m1_ack(m1_ack), .m1_data_r(m1_data_r), .m1_data_r_en(m1_data_r_en),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_rh_wl(sdram_rh_wl),
        .sdram_data_w(sdram_data_w), .sdram_ack(sdram_ack), .sdram_data_r(sdram_data_r),
        .sdram_data_r_en(sdram_data_r_en), .rd_timeout(rd_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the SDRAM port, what it is doing, and how long a read may wait.
    int            busy_phase;   // 0 free, 1 command outstanding, 2 awaiting read data
    int            owner;
    int            last_win;
    int            wait_left;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic          exp_rh;
    logic [DW-1:0] exp_dw;
    logic [1:0]    exp_ack;
    logic [1:0]    exp_dren;
    logic [DW-1:0] exp_dr [2];
    logic          exp_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_phase = 0; owner = 0; last_win = 1; wait_left = 0;
        exp_req = 0; exp_addr = '0; exp_rh = 1; exp_dw = '0;
        exp_ack = '0; exp_dren = '0; exp_dr[0] = '0; exp_dr[1] = '0; exp_to = 0;
    endtask

    task automatic model_update();
        logic want0, want1;
        int   g;
        if (!reset_l) begin
            model_reset();
            return;
        end
        want0 = m0_req && !exp_ack[0];
        want1 = m1_req && !exp_ack[1];
        exp_ack = '0; exp_dren = '0; exp_to = 0;
        if (busy_phase == 0) begin
            if (want0 || want1) begin
                if (want0 && want1) g = (last_win == 0) ? 1 : 0;
                else                g = want0 ? 0 : 1;
                exp_req  = 1;
                exp_addr = (g == 0) ? m0_addr   : m1_addr;
                exp_rh   = (g == 0) ? m0_rh_wl  : m1_rh_wl;
                exp_dw   = (g == 0) ? m0_data_w : m1_data_w;
                owner = g; last_win = g; busy_phase = 1;
            end
        end else if (busy_phase == 1) begin
            if (sdram_ack) begin
                exp_req = 0;
                exp_ack[owner] = 1;
                if (exp_rh) begin busy_phase = 2; wait_left = TO; end
                else busy_phase = 0;
            end
        end else begin
            if (sdram_data_r_en) begin
                exp_dr[owner]   = sdram_data_r;
                exp_dren[owner] = 1;
                busy_phase = 0;
            end else begin
                wait_left--;
                if (wait_left == 0) begin exp_to = 1; busy_phase = 0; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #2;
    endtask

    always @(negedge clk) begin
        chk("sdram_req",    sdram_req,    exp_req);
        chk("sdram_addr",   sdram_addr,   exp_addr);
        chk("sdram_rh_wl",  sdram_rh_wl,  exp_rh);
        chk("sdram_data_w", sdram_data_w, exp_dw);
        chk("m0_ack",       m0_ack,       exp_ack[0]);
        chk("m1_ack",       m1_ack,       exp_ack[1]);
        chk("m0_data_r_en", m0_data_r_en, exp_dren[0]);
        chk("m1_data_r_en", m1_data_r_en, exp_dren[1]);
        chk("m0_data_r",    m0_data_r,    exp_dr[0]);
        chk("m1_data_r",    m1_data_r,    exp_dr[1]);
        chk("rd_timeout",   rd_timeout,   exp_to);
    end

    task automatic rand_port(input int n);
        logic req, ack;
        req = (n == 0) ? m0_req : m1_req;
        ack = exp_ack[n];
        if ((ack && $urandom_range(1, 0) == 1) || (!req && $urandom_range(2, 0) == 0)) begin
            if (n == 0) begin
                m0_req = 1; m0_addr = AW'($urandom); m0_rh_wl = $urandom_range(1, 0) == 1;
                m0_data_w = DW'($urandom);
            end else begin
                m1_req = 1; m1_addr = AW'($urandom); m1_rh_wl = $urandom_range(1, 0) == 1;
                m1_data_w = DW'($urandom);
            end
        end else if (ack || (req && owner == n && busy_phase != 0 && $urandom_range(15, 0) == 0)) begin
            if (n == 0) m0_req = 0; else m1_req = 0;
        end
    endtask

    initial begin
        int n;
        int grants [$];
        logic seen_en;
        model_reset();
        repeat (3) tick();
        chk("rst_sdram_req", sdram_req, 1'b0);
        chk("rst_rh_wl", sdram_rh_wl, 1'b1);
        reset_l = 1;
        tick();

        // Single write from port 0, acked three cycles after the request appears
        m0_req = 1; m0_addr = 24'h000123; m0_data_w = 16'hBEEF; m0_rh_wl = 0;
        tick();
        chk("wr_req", sdram_req, 1'b1);
        chk("wr_addr", sdram_addr, 24'h000123);
        chk("wr_data", sdram_data_w, 16'hBEEF);
        chk("wr_rh_wl", sdram_rh_wl, 1'b0);
        tick(); tick();
        sdram_ack = 1;
        tick();
        chk("wr_ack", m0_ack, 1'b1);
        chk("wr_m1_quiet", m1_ack, 1'b0);
        sdram_ack = 0; m0_req = 0;
        tick();
        chk("wr_ack_one_pulse", m0_ack, 1'b0);

        // Read from port 1, data five cycles after the ack
        m1_req = 1; m1_addr = 24'h00ABCD; m1_rh_wl = 1;
        tick();
        chk("rd_addr", sdram_addr, 24'h00ABCD);
        sdram_ack = 1;
        tick();
        chk("rd_ack", m1_ack, 1'b1);
        sdram_ack = 0; m1_req = 0;
        repeat (4) tick();
        sdram_data_r_en = 1; sdram_data_r = 16'h1234;
        tick();
        chk("rd_data_en", m1_data_r_en, 1'b1);
        chk("rd_data", m1_data_r, 16'h1234);
        sdram_data_r_en = 0; sdram_data_r = 16'h0000;
        tick();
        chk("rd_data_hold", m1_data_r, 16'h1234);

        // Contention: both ports writing continuously, controller always acking
        m0_req = 1; m0_addr = 24'h000010; m0_rh_wl = 0;
        m1_req = 1; m1_addr = 24'h000020; m1_rh_wl = 0;
        sdram_ack = 1;
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            tick();
            n++;
            chk("no_double_ack", {m1_ack, m0_ack} == 2'b11, 1'b0);
            if (m0_ack) grants.push_back(0);
            if (m1_ack) grants.push_back(1);
        end
        m0_req = 0; m1_req = 0;
        chk("cont_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) chk("cont_order", (i < grants.size()) ? grants[i] : -1, i % 2);
        repeat (2) tick();
        sdram_ack = 0;
        repeat (2) tick();

        // Spurious controller strobes while idle
        sdram_ack = 1; sdram_data_r_en = 1; sdram_data_r = 16'hFFFF;
        tick();
        chk("spur_ack", {m1_ack, m0_ack}, 2'b00);
        chk("spur_en", {m1_data_r_en, m0_data_r_en}, 2'b00);
        chk("spur_hold", m1_data_r, 16'h1234);
        sdram_ack = 0; sdram_data_r_en = 0;
        tick();
        chk("spur_no_req", sdram_req, 1'b0);

        // Read timeout: no data ever arrives
        m0_req = 1; m0_addr = 24'h000555; m0_rh_wl = 1;
        tick();
        sdram_ack = 1;
        tick();
        chk("to_ack", m0_ack, 1'b1);
        sdram_ack = 0; m0_req = 0;
        n = 0; seen_en = 0;
        while (!rd_timeout && n < 30) begin
            tick();
            n++;
            if (m0_data_r_en) seen_en = 1;
        end
        chk("to_cycles", n, TO);
        chk("to_no_data", seen_en, 1'b0);
        m1_req = 1; m1_addr = 24'h000999; m1_rh_wl = 0;
        tick();
        chk("after_to_req", sdram_req, 1'b1);
        chk("after_to_addr", sdram_addr, 24'h000999);
        sdram_ack = 1;
        tick();
        sdram_ack = 0; m1_req = 0;
        tick();

        // Data in the very last allowed wait cycle beats the timeout
        m0_req = 1; m0_addr = 24'h000666; m0_rh_wl = 1;
        tick();
        sdram_ack = 1;
        tick();
        sdram_ack = 0; m0_req = 0;
        repeat (TO - 1) tick();
        sdram_data_r_en = 1; sdram_data_r = 16'h5A5A;
        tick();
        chk("race_data_en", m0_data_r_en, 1'b1);
        chk("race_no_to", rd_timeout, 1'b0);
        chk("race_data", m0_data_r, 16'h5A5A);
        sdram_data_r_en = 0;
        tick();

        // Reset while waiting for read data
        m1_req = 1; m1_addr = 24'h000777; m1_rh_wl = 1;
        tick();
        sdram_ack = 1;
        tick();
        sdram_ack = 0; m1_req = 0;
        repeat (2) tick();
        reset_l = 0;
        model_reset();
        #1;
        chk("mrst_req", sdram_req, 1'b0);
        chk("mrst_addr", sdram_addr, 24'h0);
        chk("mrst_rh_wl", sdram_rh_wl, 1'b1);
        chk("mrst_m1_data_r", m1_data_r, 16'h0);
        sdram_data_r_en = 1; sdram_data_r = 16'h1111;
        tick(); tick();
        sdram_data_r_en = 0;
        m0_req = 1; m0_addr = 24'h000AAA; m0_rh_wl = 0;
        m1_req = 1; m1_addr = 24'h000BBB; m1_rh_wl = 0;
        reset_l = 1;
        tick();
        chk("mrst_first_grant", sdram_addr, 24'h000AAA);
        chk("mrst_no_late_data", m1_data_r_en, 1'b0);
        m0_req = 0; m1_req = 0;
        sdram_ack = 1;
        repeat (2) tick();
        sdram_ack = 0;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rand_port(0);
            rand_port(1);
            sdram_ack       = $urandom_range(2, 0) == 0;
            sdram_data_r_en = $urandom_range(4, 0) == 0;
            sdram_data_r    = DW'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arb2.md
SDRAM_ARB2 -- requirements
Module: sdram_arb2

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word address width.
REQ-002 Parameter DATA_W, default 16, SDRAM data width.
REQ-003 Parameter RD_TIMEOUT, default 255, maximum number of WAIT_RD cycles before abort (1..65535).
REQ-004 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 Ports: reset_l  in  1  reset, asynchronous, active-low.
REQ-006 Ports: mN_req  in  1  requester N (N=0,1) transaction request; held until mN_ack.
REQ-007 Ports: mN_addr  in  ADDR_W, mN_rh_wl  in  1 (1=read, 0=write), mN_data_w  in  DATA_W; stable while mN_req is high.
REQ-008 Ports: mN_ack  out  1  one-cycle pulse, command accepted by SDRAM.
REQ-009 Ports: mN_data_r  out  DATA_W, mN_data_r_en  out  1  read data and one-cycle valid pulse.
REQ-010 Ports: sdram_req  out  1, sdram_addr  out  ADDR_W, sdram_rh_wl  out  1, sdram_data_w  out  DATA_W  to the SDRAM controller, all registered.
REQ-011 Ports: sdram_ack  in  1, sdram_data_r  in  DATA_W, sdram_data_r_en  in  1  from the SDRAM controller.
REQ-012 Ports: rd_timeout  out  1  one-cycle pulse on read abort.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE and WAIT_RD, plus a 1-bit last_grant register and a RD_TIMEOUT-capable down-counter.
REQ-014 In IDLE, a port is eligible when mN_req=1 and mN_ack=0 in that cycle; a port whose ack is pulsing is masked to prevent double grant.
REQ-015 In IDLE with one eligible port, that port SHALL be granted; with both eligible, the port != last_grant SHALL be granted (round-robin).
REQ-016 On grant, sdram_addr/rh_wl/data_w SHALL latch the granted port's inputs, sdram_req SHALL be set to 1, last_grant SHALL be updated, and the FSM SHALL enter ISSUE; latency from mN_req to sdram_req is 1 cycle.
REQ-017 In ISSUE, sdram_req and the latched fields SHALL stay constant until sdram_ack=1.
REQ-018 On sdram_ack in ISSUE: sdram_req<=0 and ack(granted)<=1 on the next edge; next state is IDLE for a write, and WAIT_RD with counter<=RD_TIMEOUT for a read.
REQ-019 In WAIT_RD, on sdram_data_r_en=1: data_r(granted)<=sdram_data_r, data_r_en(granted)<=1 for one cycle, then IDLE.
REQ-020 In WAIT_RD without data_r_en, the counter SHALL decrement; when it reaches 0: rd_timeout pulses for one cycle, no data_r_en, then IDLE.
REQ-021 If data_r_en and counter==0 occur in the same cycle, the data SHALL win (no timeout).
REQ-022 sdram_ack outside ISSUE and sdram_data_r_en outside WAIT_RD SHALL be ignored.
REQ-023 Only the granted port's ack/data_r_en SHALL pulse; mN_data_r SHALL hold its last value otherwise.
REQ-024 A requester dropping mN_req during ISSUE/WAIT_RD SHALL NOT abort the transaction.

Reset
REQ-025 Asserting reset_l=0 SHALL immediately force: state=IDLE, last_grant=1 (port 0 wins first tie), sdram_req=0, sdram_addr=0, sdram_rh_wl=1, sdram_data_w=0, all mN_ack/mN_data_r_en/rd_timeout=0, mN_data_r=0, counter=0.
REQ-026 Reset during ISSUE or WAIT_RD SHALL abandon the transaction without any ack or data pulse; the first grant is allowed on the first edge after deassertion.

Verification
REQ-027 Single write: m0 req, addr=0x000123, data=0xBEEF, rh_wl=0; sdram_ack 3 cycles later -> sdram_req high 1 cycle after req, fields match, m0_ack one pulse after ack, back to IDLE, m1 outputs quiet.
REQ-028 Read: m1 read addr=0x00ABCD; sdram_ack, then data_r_en with 0x1234 5 cycles later -> m1_ack pulse, then m1_data_r=0x1234 with m1_data_r_en one cycle.
REQ-029 Contention: both ports request continuously from reset -> grants alternate 0,1,0,1 over 4 writes, no double grant while ack pulses.
REQ-030 Timeout: RD_TIMEOUT=8, read acked, data_r_en never arrives -> rd_timeout pulses 8 cycles into WAIT_RD, no m0_data_r_en, next request is served.
REQ-031 Spurious inputs: sdram_ack and data_r_en pulsed in IDLE -> no ack/data pulses, no state change; data_r_en and timeout in the same cycle -> data delivered, no rd_timeout.
REQ-032 Mid-operation reset: reset_l=0 in WAIT_RD -> all outputs at reset values, later data_r_en ignored, and the first request after release gets port 0 priority.
